// File: rtl/gate_tree_eval.sv
// Runtime-programmable pipelined binary gate tree: 2**LEVELS leaves reduced to one bit through
// LEVELS ranks of AND/OR/XOR/BUF nodes. Optional golden compare enabled by GATE_TREE_CMP_EN.
module gate_tree_eval #(
  parameter int LEVELS = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  output logic                 cfg_ready,
  input  logic                 cfg_valid,
  input  logic [1:0]           cfg_op,
  output logic                 cfg_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2**LEVELS-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_data
`ifdef GATE_TREE_CMP_EN
  ,
  input  logic                 in_gold,
  output logic                 out_miss,
  output logic [CNT_W-1:0]     miss_cnt
`endif
);
  localparam int N_IN  = 2**LEVELS;
  localparam int NODES = N_IN - 1;
  localparam int BOT0  = 2**(LEVELS-1) - 1;
  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NODES - 1);

  typedef enum logic {RUN, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NODES-1:0][1:0]   op_q, op_d;
  logic [NODES-1:0]        val_q, val_d, node_y;
  logic [LEVELS:1]         vld_pipe_q, vld_pipe_d;
  logic                    cfg_done_q, cfg_done_d;
  logic                    advance, accept, start_acc;

  function automatic logic node_eval(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   node_eval = a & b;
      2'b01:   node_eval = a | b;
      2'b10:   node_eval = a ^ b;
      default: node_eval = a;
    endcase
  endfunction

  // Bottom rank reads leaves directly; upper ranks read their children's registered values,
  // so each rank is one pipeline stage.
  for (genvar i = 0; i < NODES; i++) begin : g_node
    if (i >= BOT0) begin : g_leaf
      assign node_y[i] = node_eval(op_q[i], in_data[2*(i-BOT0)], in_data[2*(i-BOT0)+1]);
    end else begin : g_inner
      assign node_y[i] = node_eval(op_q[i], val_q[2*i+1], val_q[2*i+2]);
    end
  end

  assign advance   = !vld_pipe_q[LEVELS] | out_ready;
  assign in_ready  = (state_q == RUN) & advance;
  assign cfg_ready = (state_q == RUN) & ~|vld_pipe_q;
  assign accept    = in_valid & in_ready;
  // A vector accepted in the same cycle wins; the start must be re-issued after drain.
  assign start_acc = cfg_start & cfg_ready & ~accept;

  assign out_valid = vld_pipe_q[LEVELS];
  assign out_data  = val_q[0];
  assign cfg_done  = cfg_done_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    cfg_done_d = 1'b0;
    val_d      = advance ? node_y : val_q;
    vld_pipe_d = vld_pipe_q;
    if (advance) begin
      vld_pipe_d[1] = accept;
      for (int k = 2; k <= LEVELS; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    end
    case (state_q)
      RUN: begin
        if (start_acc) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        if (cfg_start) begin
          idx_d = '0;
        end else if (cfg_valid) begin
          op_d[idx_q] = cfg_op;
          if (idx_q == LAST) begin
            state_d    = RUN;
            idx_d      = '0;
            cfg_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      idx_q      <= '0;
      op_q       <= '0;
      val_q      <= '0;
      vld_pipe_q <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      val_q      <= val_d;
      vld_pipe_q <= vld_pipe_d;
      cfg_done_q <= cfg_done_d;
    end
  end

`ifdef GATE_TREE_CMP_EN
  logic [LEVELS:1]  gold_pipe_q, gold_pipe_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  assign out_miss = out_data ^ gold_pipe_q[LEVELS];
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    gold_pipe_d = gold_pipe_q;
    if (advance) begin
      gold_pipe_d[1] = in_gold;
      for (int k = 2; k <= LEVELS; k++) gold_pipe_d[k] = gold_pipe_q[k-1];
    end
    miss_cnt_d = miss_cnt_q;
    if (start_acc)
      miss_cnt_d = '0;
    else if (out_valid && out_ready && out_miss && !(&miss_cnt_q))
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gold_pipe_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      gold_pipe_q <= gold_pipe_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_gate_tree_eval.sv
// Directed bench for gate_tree_eval (LEVELS=3): defaults, XOR parity, OR/AND stream with stall,
// cfg handshake against in-flight data, reset mid-load, and the optional compare feature.
module tb_gate_tree_eval;
  localparam int LEVELS = 3;
  localparam int N_IN   = 8;
  localparam int NODES  = 7;
  localparam int CNT_W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start, cfg_ready, cfg_valid, cfg_done;
  logic [1:0]      cfg_op;
  logic            in_valid, in_ready;
  logic [N_IN-1:0] in_data;
  logic            out_valid, out_ready, out_data;
`ifdef GATE_TREE_CMP_EN
  logic            in_gold, out_miss;
  logic [CNT_W-1:0] miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  gate_tree_eval #(.LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_ready(cfg_ready), .cfg_valid(cfg_valid),
    .cfg_op(cfg_op), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef GATE_TREE_CMP_EN
    , .in_gold(in_gold), .out_miss(out_miss), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input logic [N_IN-1:0] d, input logic e, input string nm);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (LEVELS-1) tick;
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++;
      $display("FAIL %s: out_valid=%b out_data=%b expected valid=1 data=%b", nm, out_valid, out_data, e);
    end
    tick;
  endtask

  task automatic load_ops(input logic [NODES-1:0][1:0] ops);
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < NODES; i++) begin
      cfg_op = ops[i];
      tick;
    end
    cfg_valid = 1'b0;
    checks++;
    if (cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL load_done: cfg_done=%b expected 1", cfg_done);
    end
    tick;
  endtask

  task automatic test_reset;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 1'b0 || cfg_done !== 1'b0 ||
        in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: ov=%b od=%b done=%b ir=%b cr=%b expected 0 0 0 1 1",
               out_valid, out_data, cfg_done, in_ready, cfg_ready);
    end
`ifdef GATE_TREE_CMP_EN
    checks++;
    if (miss_cnt !== '0) begin
      failures++;
      $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt);
    end
`endif
  endtask

  task automatic test_default_and;
    send_exp(8'hFF, 1'b1, "and_ff");
    send_exp(8'hFE, 1'b0, "and_fe");
  endtask

  task automatic test_xor_load;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_ready: cfg_ready=%b in_ready=%b expected 0 0", cfg_ready, in_ready);
    end
    cfg_valid = 1'b1; cfg_op = 2'b10;
    for (int i = 0; i < NODES; i++) begin
      tick;
      if (i == NODES-2) begin
        checks++;
        if (cfg_done !== 1'b0) begin
          failures++;
          $display("FAIL done_early: cfg_done=%b expected 0", cfg_done);
        end
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse: cfg_done=%b expected 1", cfg_done);
    end
    tick;
    checks++;
    if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_clear: cfg_done=%b cfg_ready=%b expected 0 1", cfg_done, cfg_ready);
    end
    send_exp(8'h01, 1'b1, "xor_01");
    send_exp(8'h03, 1'b0, "xor_03");
    send_exp(8'hB7, 1'b0, "xor_b7");
  endtask

  task automatic test_back_to_back;
    logic [N_IN-1:0] vec [4];
    logic            expv [4];
    int sent = 0, got = 0, stalls = 0;
    logic held = 1'b0, prev_stall = 1'b0;
    vec  = '{8'hF0, 8'h0F, 8'h3C, 8'h00};
    expv = '{1'b1, 1'b1, 1'b0, 1'b0};
    load_ops({2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01});
    for (int c = 0; c < 40 && got < 4; c++) begin
      in_valid  = (sent < 4);
      in_data   = vec[(sent < 4) ? sent : 0];
      out_ready = !(got == 1 && stalls < 2);
      #1;
      if (out_valid && !out_ready) begin
        if (prev_stall) begin
          checks++;
          if (out_data !== held) begin
            failures++;
            $display("FAIL stall_stable: out_data=%b expected %b", out_data, held);
          end
        end
        held = out_data; prev_stall = 1'b1; stalls++;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== expv[got]) begin
          failures++;
          $display("FAIL stream_%0d: out_data=%b expected %b", got, out_data, expv[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 4 || stalls != 2) begin
      failures++;
      $display("FAIL stream_count: got=%0d stalls=%0d expected 4 2", got, stalls);
    end
  endtask

  task automatic test_simul_start;
    cfg_start = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    tick;
    cfg_start = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_start: in_ready=%b cfg_ready=%b expected 1 0", in_ready, cfg_ready);
    end
    for (int c = 0; c < 20 && !cfg_ready; c++) tick;
  endtask

  task automatic test_cfg_inflight;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF;
    tick;
    in_data = 8'h00;
    tick;
    in_valid = 1'b0;
    cfg_start = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready: cfg_ready=%b expected 0", cfg_ready);
    end
    tick;
    cfg_start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stay_run: in_ready=%b expected 1", in_ready);
    end
    for (int c = 0; c < 20 && !cfg_ready; c++) tick;
    checks++;
    if (cfg_ready !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: cfg_ready=%b in_ready=%b out_valid=%b expected 1 1 0",
               cfg_ready, in_ready, out_valid);
    end
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_entered: in_ready=%b cfg_ready=%b expected 0 0", in_ready, cfg_ready);
    end
  endtask

  // Expects to be entered in LOAD; three OR beats then an asynchronous reset.
  task automatic test_reset_midload;
    cfg_valid = 1'b1; cfg_op = 2'b01;
    repeat (3) tick;
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b1 || cfg_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_midload: ov=%b cr=%b ir=%b done=%b expected 0 1 1 0",
               out_valid, cfg_ready, in_ready, cfg_done);
    end
    @(negedge clk);
    rst = 1'b0;
    tick;
    send_exp(8'hFF, 1'b1, "rst_and_ff");
    send_exp(8'h7F, 1'b0, "rst_and_7f");
  endtask

`ifdef GATE_TREE_CMP_EN
  task automatic test_cmp;
    logic [N_IN-1:0] vec [3];
    logic            gold [3];
    logic            expm [3];
    vec  = '{8'hFF, 8'hFF, 8'h00};
    gold = '{1'b1, 1'b0, 1'b1};
    expm = '{1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      in_valid = 1'b1; in_data = vec[v]; in_gold = gold[v];
      tick;
      in_valid = 1'b0; in_gold = 1'b0;
      repeat (LEVELS-1) tick;
      checks++;
      if (out_valid !== 1'b1 || out_miss !== expm[v]) begin
        failures++;
        $display("FAIL miss_%0d: out_valid=%b out_miss=%b expected 1 %b", v, out_valid, out_miss, expm[v]);
      end
      tick;
    end
    checks++;
    if (miss_cnt !== 16'd2) begin
      failures++;
      $display("FAIL miss_cnt: got %0d expected 2", miss_cnt);
    end
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    checks++;
    if (miss_cnt !== 16'd0) begin
      failures++;
      $display("FAIL miss_clear: got %0d expected 0", miss_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_op = 2'b00;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef GATE_TREE_CMP_EN
    in_gold = 1'b0;
`endif
    #12 rst = 1'b0;
    tick;
    test_reset;
    test_default_and;
    test_xor_load;
    test_back_to_back;
    test_simul_start;
    test_cfg_inflight;
    test_reset_midload;
`ifdef GATE_TREE_CMP_EN
    test_cmp;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
